// File: rtl/traffic_light_pkg.sv
// Shared types and helpers for the traffic light protocol monitor.
package traffic_light_pkg;

   typedef enum logic [1:0] {
      RED     = 2'b00,
      GREEN   = 2'b01,
      YELLOW  = 2'b10,
      INVALID = 2'b11
   } light_t;

   typedef enum logic {
      AXIS_NS = 1'b0,
      AXIS_EW = 1'b1
   } axis_t;

   localparam int NUM_DIRS = 4;   // index order n, e, s, w

   localparam int ERR_CONFLICT = 0;
   localparam int ERR_SEQUENCE = 1;
   localparam int ERR_TIMING   = 2;
   localparam int ERR_ENCODING = 3;

   function automatic logic is_legal_transition(light_t from, light_t to);
      return (from == RED    && to == GREEN)  ||
             (from == GREEN  && to == YELLOW) ||
             (from == YELLOW && to == RED);
   endfunction

   // Odd direction indices (e, w) sit on the east-west axis.
   function automatic axis_t dir_axis(int d);
      return (d % 2 == 1) ? AXIS_EW : AXIS_NS;
   endfunction

   function automatic logic [2:0] popcount4(logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/traffic_light_monitor_dir.sv
// Per-direction history: previous light and saturating dwell counter.
module tlm_dir_tracker
   import traffic_light_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       light,
   output light_t           cur_state,
   output logic             chg,
   output light_t           old_state,
   output logic [CNT_W-1:0] old_dwell
);

   light_t           prev;
   logic [CNT_W-1:0] dwell;

   assign cur_state = light_t'(light);
   assign chg       = (cur_state != prev);
   assign old_state = prev;
   assign old_dwell = dwell;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev  <= RED;
         dwell <= '0;
      end else if (chg) begin
         prev  <= cur_state;
         dwell <= CNT_W'(1);
      end else if (dwell != '1) begin
         dwell <= dwell + CNT_W'(1);
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the four traffic light buses; flags conflict, sequence,
// timing and encoding errors. Optional err_count output under TLM_ERR_COUNT_EN.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int CNT_W           = 16,
   parameter int GREEN_MIN_CYC   = 100,
   parameter int YELLOW_MIN_CYC  = 40,
   parameter int YELLOW_MAX_CYC  = 60,
   parameter int ALL_RED_MIN_CYC = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  n_light,
   input  logic [1:0]  e_light,
   input  logic [1:0]  s_light,
   input  logic [1:0]  w_light,
   input  logic        clear_err,
   output logic        err_conflict,
   output logic        err_sequence,
   output logic        err_timing,
   output logic        err_encoding,
   output logic [3:0]  err_sticky,
   output logic [3:0]  err_dir,
   output logic [15:0] green_count
`ifdef TLM_ERR_COUNT_EN
   ,output logic [15:0] err_count
`endif
);

   logic [NUM_DIRS-1:0][1:0] lights;
   light_t                   cur_st    [NUM_DIRS];
   light_t                   old_st    [NUM_DIRS];
   logic [CNT_W-1:0]         old_dwell [NUM_DIRS];
   logic [NUM_DIRS-1:0]      chg;

   assign lights = {w_light, s_light, e_light, n_light};

   for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
      tlm_dir_tracker #(.CNT_W(CNT_W)) u_trk (
         .clk       (clk),
         .reset     (reset),
         .light     (lights[d]),
         .cur_state (cur_st[d]),
         .chg       (chg[d]),
         .old_state (old_st[d]),
         .old_dwell (old_dwell[d])
      );
   end

   logic             armed;
   logic             last_axis_valid;
   axis_t            last_axis;
   logic [CNT_W-1:0] clr_cnt;
   logic [3:0]       pulse_q;

   logic [3:0]          pulse;
   logic [NUM_DIRS-1:0] dir_hit;
   logic [NUM_DIRS-1:0] rg_evt;
   logic [NUM_DIRS-1:0] non_red;
   logic                ns_act;
   logic                ew_act;

   always_comb begin
      pulse   = '0;
      dir_hit = '0;
      rg_evt  = '0;
      non_red = '0;
      for (int d = 0; d < NUM_DIRS; d++) begin
         non_red[d] = (cur_st[d] != RED);
         if (cur_st[d] == INVALID) begin
            pulse[ERR_ENCODING] = 1'b1;
            dir_hit[d]          = 1'b1;
         end
         if (chg[d]) begin
            if (old_st[d] == RED && cur_st[d] == GREEN)
               rg_evt[d] = 1'b1;
            // The first sample after reset only seeds history.
            if (armed && old_st[d] != INVALID && cur_st[d] != INVALID) begin
               if (!is_legal_transition(old_st[d], cur_st[d])) begin
                  pulse[ERR_SEQUENCE] = 1'b1;
                  dir_hit[d]          = 1'b1;
               end else if ((old_st[d] == GREEN  && old_dwell[d] < CNT_W'(GREEN_MIN_CYC)) ||
                            (old_st[d] == YELLOW && old_dwell[d] < CNT_W'(YELLOW_MIN_CYC))) begin
                  pulse[ERR_TIMING] = 1'b1;
                  dir_hit[d]        = 1'b1;
               end
            end
         end else if (cur_st[d] == YELLOW && old_dwell[d] == CNT_W'(YELLOW_MAX_CYC)) begin
            pulse[ERR_TIMING] = 1'b1;
            dir_hit[d]        = 1'b1;
         end
         if (rg_evt[d] && last_axis_valid && dir_axis(d) != last_axis &&
             clr_cnt < CNT_W'(ALL_RED_MIN_CYC)) begin
            pulse[ERR_TIMING] = 1'b1;
            dir_hit[d]        = 1'b1;
         end
      end
      ns_act = non_red[0] | non_red[2];
      ew_act = non_red[1] | non_red[3];
      if (ns_act && ew_act) begin
         pulse[ERR_CONFLICT] = 1'b1;
         dir_hit             = dir_hit | non_red;
      end
   end

   logic [16:0] gc_sum;
   assign gc_sum = {1'b0, green_count} + 17'(popcount4(rg_evt));

   always_ff @(posedge clk) begin
      if (reset) begin
         armed           <= 1'b0;
         last_axis_valid <= 1'b0;
         last_axis       <= AXIS_NS;
         clr_cnt         <= '0;
         pulse_q         <= '0;
         err_sticky      <= '0;
         err_dir         <= '0;
         green_count     <= '0;
      end else begin
         armed      <= 1'b1;
         pulse_q    <= pulse;
         err_sticky <= (clear_err ? 4'b0 : err_sticky) | pulse;
         err_dir    <= (clear_err ? 4'b0 : err_dir) | dir_hit;
         if (|non_red)
            clr_cnt <= '0;
         else if (clr_cnt != '1)
            clr_cnt <= clr_cnt + CNT_W'(1);
         if (|rg_evt) begin
            last_axis       <= (rg_evt[1] | rg_evt[3]) ? AXIS_EW : AXIS_NS;
            last_axis_valid <= 1'b1;
         end
         green_count <= gc_sum[16] ? 16'hFFFF : gc_sum[15:0];
      end
   end

   assign err_conflict = pulse_q[ERR_CONFLICT];
   assign err_sequence = pulse_q[ERR_SEQUENCE];
   assign err_timing   = pulse_q[ERR_TIMING];
   assign err_encoding = pulse_q[ERR_ENCODING];

`ifdef TLM_ERR_COUNT_EN
   logic [16:0] ec_sum;
   assign ec_sum = {1'b0, (clear_err ? 16'h0 : err_count)} + 17'(popcount4(pulse));

   always_ff @(posedge clk) begin
      if (reset)
         err_count <= '0;
      else
         err_count <= ec_sum[16] ? 16'hFFFF : ec_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with a timestamp-based reference model.
module tb_traffic_light_monitor;

   localparam logic [1:0] R = 2'b00, G = 2'b01, Y = 2'b10, X = 2'b11;
   localparam int GMIN = 100, YMIN = 40, YMAX = 60, ARMIN = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  n_light, e_light, s_light, w_light;
   logic        clear_err;
   logic        err_conflict, err_sequence, err_timing, err_encoding;
   logic [3:0]  err_sticky, err_dir;
   logic [15:0] green_count;
`ifdef TLM_ERR_COUNT_EN
   logic [15:0] err_count;
`endif

   traffic_light_monitor dut (
      .clk          (clk),
      .reset        (reset),
      .n_light      (n_light),
      .e_light      (e_light),
      .s_light      (s_light),
      .w_light      (w_light),
      .clear_err    (clear_err),
      .err_conflict (err_conflict),
      .err_sequence (err_sequence),
      .err_timing   (err_timing),
      .err_encoding (err_encoding),
      .err_sticky   (err_sticky),
      .err_dir      (err_dir),
      .green_count  (green_count)
`ifdef TLM_ERR_COUNT_EN
      ,.err_count   (err_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each light's history is kept as the cycle it was
   // first seen, so dwell is a subtraction rather than a counter.
   int         cyc = 0;
   bit         started = 0;
   logic [1:0] m_prev  [4];
   int         m_start [4];
   int         m_last_nonred;
   int         m_last_axis;
   bit         m_lav, m_armed;
   int         m_gc, m_ec;
   logic [3:0] exp_p = '0, exp_sticky = '0, exp_dir = '0;

   always @(posedge clk) begin : model
      logic [1:0] lt [4];
      logic [3:0] p, dh, rg;
      logic [1:0] cur, old;
      int         od;
      bit         ns, ew;
      cyc++;
      lt[0] = n_light; lt[1] = e_light; lt[2] = s_light; lt[3] = w_light;
      if (reset) begin
         for (int d = 0; d < 4; d++) begin
            m_prev[d]  = R;
            m_start[d] = cyc + 1;
         end
         m_last_nonred = cyc;
         m_last_axis = 0; m_lav = 0; m_armed = 0; m_gc = 0; m_ec = 0;
         exp_p = '0; exp_sticky = '0; exp_dir = '0;
         started = 1;
      end else begin
         p = '0; dh = '0; rg = '0;
         for (int d = 0; d < 4; d++) begin
            cur = lt[d];
            old = m_prev[d];
            od  = cyc - m_start[d];
            if (cur == X) begin p[3] = 1; dh[d] = 1; end
            if (cur != old) begin
               if (old == R && cur == G) rg[d] = 1;
               if (m_armed && cur != X && old != X) begin
                  if (!((old == R && cur == G) || (old == G && cur == Y) || (old == Y && cur == R))) begin
                     p[1] = 1; dh[d] = 1;
                  end else if ((old == G && od < GMIN) || (old == Y && od < YMIN)) begin
                     p[2] = 1; dh[d] = 1;
                  end
               end
               m_prev[d]  = cur;
               m_start[d] = cyc;
            end else if (cur == Y && od + 1 == YMAX + 1) begin
               p[2] = 1; dh[d] = 1;
            end
            if (rg[d] && m_lav && (d % 2) != m_last_axis && (cyc - 1 - m_last_nonred) < ARMIN) begin
               p[2] = 1; dh[d] = 1;
            end
         end
         ns = (lt[0] != R) || (lt[2] != R);
         ew = (lt[1] != R) || (lt[3] != R);
         if (ns && ew) begin
            p[0] = 1;
            for (int d = 0; d < 4; d++) if (lt[d] != R) dh[d] = 1;
         end
         if (ns || ew) m_last_nonred = cyc;
         if (rg != 0) begin
            m_last_axis = (rg[1] || rg[3]) ? 1 : 0;
            m_lav = 1;
         end
         m_gc += $countones(rg);
         m_ec = (clear_err ? 0 : m_ec) + $countones(p);
         m_armed = 1;
         exp_p = p;
         exp_sticky = (clear_err ? 4'b0 : exp_sticky) | p;
         exp_dir    = (clear_err ? 4'b0 : exp_dir) | dh;
      end
   end

   int cnt_p [4];

   always @(negedge clk) begin
      if (started) begin
         chk("pulses", 32'({err_encoding, err_timing, err_sequence, err_conflict}), 32'(exp_p));
         chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
         chk("err_dir", 32'(err_dir), 32'(exp_dir));
         chk("green_count", 32'(green_count), m_gc);
`ifdef TLM_ERR_COUNT_EN
         chk("err_count", 32'(err_count), m_ec);
`endif
         cnt_p[0] += int'(err_conflict);
         cnt_p[1] += int'(err_sequence);
         cnt_p[2] += int'(err_timing);
         cnt_p[3] += int'(err_encoding);
      end
   end

   task automatic set_l(input logic [1:0] n, input logic [1:0] e, input logic [1:0] s, input logic [1:0] w);
      n_light = n; e_light = e; s_light = s; w_light = w;
   endtask

   // Lights set before hold(k) are sampled exactly k times.
   task automatic hold(input int k);
      repeat (k) @(negedge clk);
      #1;
   endtask

   task automatic zero_cnt();
      for (int i = 0; i < 4; i++) cnt_p[i] = 0;
   endtask

   task automatic clear_alone();
      clear_err = 1'b1;
      hold(1);
      clear_err = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, 32'({err_encoding, err_timing, err_sequence, err_conflict, err_sticky, err_dir}), 32'h0);
      chk({name, "_gc"}, 32'(green_count), 32'h0);
   endtask

   initial begin
      reset = 1'b1; clear_err = 1'b0;
      set_l(R, R, R, R);
      hold(2);
      chk_all_zero("reset_outputs");
      reset = 1'b0;
      hold(3);

      // Legal full cycle.
      zero_cnt();
      set_l(G, R, G, R); hold(100);
      set_l(Y, R, Y, R); hold(50);
      set_l(R, R, R, R); hold(10);
      set_l(R, G, R, G); hold(100);
      set_l(R, Y, R, Y); hold(50);
      set_l(R, R, R, R); hold(12);
      chk("legal_green_count", 32'(green_count), 32'd4);
      chk("legal_no_pulses", 32'(cnt_p[0] + cnt_p[1] + cnt_p[2] + cnt_p[3]), 32'd0);
      chk("legal_sticky", 32'(err_sticky), 32'h0);

      // Conflict between n GREEN and e YELLOW.
      clear_alone();
      zero_cnt();
      set_l(G, Y, R, R); hold(3);
      set_l(R, R, R, R); hold(3);
      chk("conflict_cycles", 32'(cnt_p[0]), 32'd3);
      chk("conflict_dir", 32'(err_dir), 32'b0011);
      chk("conflict_sticky0", 32'(err_sticky[0]), 32'd1);

      // n GREEN straight to RED.
      clear_alone();
      zero_cnt();
      set_l(G, R, R, R); hold(100);
      set_l(R, R, R, R); hold(3);
      chk("badseq_seq", 32'(cnt_p[1]), 32'd1);
      chk("badseq_timing", 32'(cnt_p[2]), 32'd0);

      // Yellow held 61 cycles.
      zero_cnt();
      set_l(G, R, R, R); hold(100);
      set_l(Y, R, R, R); hold(61);
      set_l(R, R, R, R); hold(3);
      chk("ymax_timing", 32'(cnt_p[2]), 32'd1);
      chk("ymax_seq", 32'(cnt_p[1]), 32'd0);

      // Green of only 99 cycles.
      zero_cnt();
      set_l(G, R, R, R); hold(99);
      set_l(Y, R, R, R); hold(45);
      set_l(R, R, R, R); hold(9);
      chk("gmin_timing", 32'(cnt_p[2]), 32'd1);

      // E GREEN after only 9 all-red cycles following NS.
      zero_cnt();
      set_l(R, G, R, R); hold(100);
      set_l(R, Y, R, R); hold(45);
      set_l(R, R, R, R); hold(10);
      chk("clearance_timing", 32'(cnt_p[2]), 32'd1);

      // INVALID encoding and clear behaviour.
      clear_alone();
      zero_cnt();
      set_l(R, R, R, X); hold(2);
      set_l(R, R, R, R); hold(3);
      chk("invalid_pulses", 32'(cnt_p[3]), 32'd2);
      chk("invalid_sticky", 32'(err_sticky), 32'b1000);
      chk("invalid_dir", 32'(err_dir), 32'b1000);
      clear_alone();
      chk("clear_sticky", 32'(err_sticky), 32'h0);
      chk("clear_dir", 32'(err_dir), 32'h0);
      clear_err = 1'b1;
      set_l(R, R, R, X); hold(1);
      clear_err = 1'b0;
      set_l(R, R, R, R); hold(2);
      chk("clear_vs_set_sticky", 32'(err_sticky), 32'b1000);
      chk("clear_vs_set_dir", 32'(err_dir), 32'b1000);

      // Reset in the middle of a YELLOW.
      set_l(R, R, R, R); hold(12);
      set_l(G, R, R, R); hold(100);
      set_l(Y, R, R, R); hold(30);
      reset = 1'b1;
      hold(1);
      chk_all_zero("midreset_outputs");
      reset = 1'b0;
      zero_cnt();
      hold(45);
      set_l(R, R, R, R); hold(5);
      chk("midreset_seq", 32'(cnt_p[1]), 32'd0);
      chk("midreset_timing", 32'(cnt_p[2]), 32'd0);
      chk("midreset_gc", 32'(green_count), 32'd0);
`ifdef TLM_ERR_COUNT_EN
      chk("midreset_err_count", 32'(err_count), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive protocol checker that reads the four 2-bit light buses driven by the traffic light controller.
- Tracks per-direction state and dwell time, and flags:
  - axis conflicts
  - illegal colour sequences
  - timing violations
  - invalid encodings
- Instantiated beside the controller top, in simulation benches and optionally on-chip for FPGA self-check.
- Has no effect on the controller; observation only.

Parameters:
- CNT_W, 16: width of dwell and clearance counters; counters saturate at 2^CNT_W-1.
- GREEN_MIN_CYC, 100: minimum cycles a direction stays GREEN before going YELLOW.
- YELLOW_MIN_CYC, 40: minimum YELLOW dwell.
- YELLOW_MAX_CYC, 60: maximum YELLOW dwell.
- ALL_RED_MIN_CYC, 10: minimum consecutive all-red cycles before the opposite axis may go GREEN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- n_light  in  2  north light
- e_light  in  2  east light
- s_light  in  2  south light
- w_light  in  2  west light
- clear_err  in  1  clears sticky status
- err_conflict  out  1  one-cycle pulse
- err_sequence  out  1  one-cycle pulse
- err_timing  out  1  one-cycle pulse
- err_encoding  out  1  one-cycle pulse
- err_sticky  out  4  {encoding,timing,sequence,conflict}, held until clear_err
- err_dir  out  4  {w,s,e,n} sticky: direction involved in any error
- green_count  out  16  saturating count of RED->GREEN transitions (all directions)

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Encoding:
  - 2'b00 RED, 2'b01 GREEN, 2'b10 YELLOW, 2'b11 INVALID.
  - Axes: NS = {n,s}, EW = {e,w}.
- Reset (reset=1 at an edge):
  - All outputs 0.
  - Per-direction prev state = RED; dwell counters = 0; clearance counter = 0.
  - last_axis_valid = 0.
  - Reset mid-operation discards all history; no error is raised on the first post-reset cycle for transitions from the reset state.
- Latency: lights present in cycle t are sampled at edge t; any resulting error pulse is high during cycle t+1 only.
- Per direction:
  - Compare the input to prev.
  - On change, capture the old dwell for checks, reload dwell = 1, then update prev.
  - Otherwise dwell increments, saturating.
- Sequence rule:
  - Legal changes are only RED->GREEN, GREEN->YELLOW, YELLOW->RED.
  - Any other change involving two legal codes raises err_sequence.
  - Changes to or from INVALID raise err_encoding only, never err_sequence.
- Timing rules:
  - GREEN->YELLOW with old dwell < GREEN_MIN_CYC: err_timing.
  - YELLOW->RED with old dwell < YELLOW_MIN_CYC: err_timing.
  - While YELLOW, err_timing on the cycle dwell reaches YELLOW_MAX_CYC+1. Single pulse per YELLOW episode; no second pulse on its YELLOW->RED.
- Conflict rule:
  - Any NS direction non-RED while any EW direction non-RED raises err_conflict.
  - Pulses every offending cycle.
  - N and S (or E and W) non-RED together is legal.
- Clearance rule:
  - Clearance counter counts consecutive cycles with all four lights RED; it clears on any non-RED.
  - On RED->GREEN on an axis different from last_axis with last_axis_valid=1: if clearance < ALL_RED_MIN_CYC, raise err_timing.
  - Every RED->GREEN sets last_axis to that axis and last_axis_valid=1.
  - The first GREEN after reset is exempt.
- INVALID: raises err_encoding every cycle present.
- Multiple errors in one cycle: all relevant pulses assert together; err_dir ORs all involved directions.
- Sticky:
  - err_sticky |= pulses each cycle.
  - clear_err zeroes err_sticky and err_dir; if a pulse occurs in the same cycle, set wins.
- green_count: increments per RED->GREEN direction event, +2 if two directions turn together; saturates at 16'hFFFF.

Optional Feature:
- Macro: TLM_ERR_COUNT_EN.
- Defined:
  - Adds output err_count[15:0]: saturating total of error pulses per cycle (popcount of the four pulses).
  - Reset to 0; cleared by clear_err, with set winning over clear.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- traffic_light_pkg holds:
  - light_t enum (RED/GREEN/YELLOW/INVALID, 2-bit)
  - axis_t enum (AXIS_NS/AXIS_EW)
  - function is_legal_transition(light_t from, light_t to)
  - error-bit index constants
- Sub-module tlm_dir_tracker, instantiated 4x:
  - Holds prev state and dwell counter.
  - Outputs the current state, a change strobe, old state and old dwell.
  - Shared by the top for sequence and timing checks.

Test Plan:
- Legal cycle: N/S GREEN 100 -> YELLOW 50 -> RED, all red 10, E/W GREEN 100 -> no error pulses; green_count=4.
- Conflict: n=GREEN, e=YELLOW for 3 cycles -> err_conflict high 3 cycles, err_dir=4'b0011, err_sticky[0]=1.
- Bad sequence: n GREEN->RED directly -> err_sequence pulse 1 cycle later; err_timing stays 0.
- Timing:
  - Yellow held 61 cycles -> single err_timing pulse at dwell 61.
  - Green of 99 cycles before YELLOW -> err_timing.
  - E GREEN after 9 all-red cycles following NS -> err_timing.
- Invalid/clear: w=2'b11 for 2 cycles -> 2 err_encoding pulses; clear_err asserted alone clears err_sticky/err_dir; clear_err coincident with an error leaves the bit set.
- Reset mid-YELLOW at dwell 30 -> all outputs 0 next cycle; subsequent YELLOW->RED is not a sequence error. With TLM_ERR_COUNT_EN: err_count matches the injected pulse total.
